// File: rtl/demux_1t2_32_pkg.sv
// Shared pipeline defines for the 1-to-2 demultiplexer.
//   DEF_WIDTH : default data word width
//   DEF_DEPTH : default entries per output buffer (power of two, >= 2)
//   DEF_CW    : default width of the per-channel transfer counters
//   ch_sel_e  : route select encoding sampled with the input word
package demux_1t2_32_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 2;
  localparam int unsigned DEF_CW    = 16;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } ch_sel_e;

endpackage

// File: rtl/demux_1t2_32_fifo_sync.sv
// Small synchronous FIFO used as a per-channel output buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din at the tail (ignored when full or flushing)
//   pop        : advance the head (ignored when empty or flushing)
//   flush      : synchronous clear of pointers and count, highest priority
//   full/empty : occupancy flags derived from the registered count
//   count      : occupancy, 0..DEPTH inclusive
//   head       : oldest entry, forced to zero while empty
module fifo_sync
  import demux_1t2_32_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign push_ok = push && !full  && !flush;
  assign pop_ok  = pop  && !empty && !flush;

  // NOTE: the storage array has no reset; head is masked to zero while the
  // FIFO is empty, so stale entries never reach the outputs.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge inputs regardless of statement order.
  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      // Simultaneous push and pop leaves the count unchanged.
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/demux_1t2_32.sv
// 1-to-2 demultiplexer with a small FIFO on each output channel.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous clear of both output buffers
//   in_valid/in_ready   : upstream handshake; in_data routed by s
//   s                   : 0 -> channel 0, 1 -> channel 1
//   ok_valid/ok_ready   : per-channel downstream handshake (k = 0, 1)
//   ok_data             : channel head word, zero while the channel is empty
//   cnt0, cnt1          : free-running count of words accepted per channel
module demux_1t2_32
  import demux_1t2_32_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CW    = DEF_CW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             s,
  output logic             o0_valid,
  input  logic             o0_ready,
  output logic [WIDTH-1:0] o0_data,
  output logic             o1_valid,
  input  logic             o1_ready,
  output logic [WIDTH-1:0] o1_data,
  output logic [CW-1:0]    cnt0,
  output logic [CW-1:0]    cnt1
);

  localparam int unsigned CNTW    = $clog2(DEPTH) + 1;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
  localparam logic [CW-1:0]   XFER_ONE = CW'(1);

  ch_sel_e         sel;
  logic [CNTW-1:0] count0;
  logic [CNTW-1:0] count1;
  logic [CNTW-1:0] sel_count;
  logic            empty0;
  logic            empty1;
  logic            full0;
  logic            full1;
  logic            unused_full;
  logic            push0;
  logic            push1;
  logic            pop0;
  logic            pop1;

  assign sel       = ch_sel_e'(s);
  assign sel_count = (sel == CH1) ? count1 : count0;

  // Ready depends only on registered counts, s and flush: a pop in the same
  // cycle does not free a slot for the incoming word. rst_n keeps it low
  // while the block is held in reset.
  assign in_ready = rst_n && !flush && (sel_count < DEPTH_C);

  assign push0 = in_valid && in_ready && (sel == CH0);
  assign push1 = in_valid && in_ready && (sel == CH1);
  assign pop0  = o0_valid && o0_ready;
  assign pop1  = o1_valid && o1_ready;

  assign o0_valid = !empty0;
  assign o1_valid = !empty1;

  // Fullness is already implied by the count comparison above.
  assign unused_full = full0 ^ full1;

  fifo_sync #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0),
    .pop   (pop0),
    .flush (flush),
    .din   (in_data),
    .full  (full0),
    .empty (empty0),
    .count (count0),
    .head  (o0_data)
  );

  fifo_sync #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .pop   (pop1),
    .flush (flush),
    .din   (in_data),
    .full  (full1),
    .empty (empty1),
    .count (count1),
    .head  (o1_data)
  );

  // Transfer counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (push0) cnt0 <= cnt0 + XFER_ONE;
      if (push1) cnt1 <= cnt1 + XFER_ONE;
    end
  end

endmodule

// File: tb/tb_demux_1t2_32.sv
// Scoreboard bench for demux_1t2_32: the driver pushes expected words per
// channel, a negedge monitor pops and compares on every output handshake.
module tb_demux_1t2_32;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        s;
  logic        o0_valid;
  logic        o0_ready;
  logic [31:0] o0_data;
  logic        o1_valid;
  logic        o1_ready;
  logic [31:0] o1_data;
  logic [15:0] cnt0;
  logic [15:0] cnt1;

  int          n_checks;
  int          n_errors;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [15:0] cnt_exp0;
  logic [15:0] cnt_exp1;
  logic        mon_en;

  demux_1t2_32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .s        (s),
    .o0_valid (o0_valid),
    .o0_ready (o0_ready),
    .o0_data  (o0_data),
    .o1_valid (o1_valid),
    .o1_ready (o1_ready),
    .o1_data  (o1_data),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus. Called just after a rising edge; in_ready is
  // compared mid-cycle against the hand-computed value, and the model is
  // updated right after the edge that performs the transfer.
  task automatic step(input logic v, input logic sel, input logic [31:0] d,
                      input logic r0, input logic r1, input logic fl,
                      input logic exp_rdy);
    in_valid = v;
    s        = sel;
    in_data  = d;
    o0_ready = r0;
    o1_ready = r1;
    flush    = fl;
    @(negedge clk);
    check("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    if (fl) begin
      q0.delete();
      q1.delete();
    end else if (v && exp_rdy) begin
      if (sel) begin
        q1.push_back(d);
        cnt_exp1 = cnt_exp1 + 16'd1;
      end else begin
        q0.push_back(d);
        cnt_exp0 = cnt_exp0 + 16'd1;
      end
    end
    #1;
  endtask

  // Monitor: outputs must mirror the scoreboard heads; a handshake pops.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("o0_valid", o0_valid, q0.size() != 0);
      if (q0.size() != 0) check("o0_data", o0_data, q0[0]);
      else                check("o0_data_idle", o0_data, 32'h0);
      if (o0_valid && o0_ready && !flush && q0.size() != 0) void'(q0.pop_front());

      check("o1_valid", o1_valid, q1.size() != 0);
      if (q1.size() != 0) check("o1_data", o1_data, q1[0]);
      else                check("o1_data_idle", o1_data, 32'h0);
      if (o1_valid && o1_ready && !flush && q1.size() != 0) void'(q1.pop_front());

      check("cnt0", {16'h0, cnt0}, {16'h0, cnt_exp0});
      check("cnt1", {16'h0, cnt1}, {16'h0, cnt_exp1});
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_o0_valid"}, o0_valid, 0);
    check({tag, "_o1_valid"}, o1_valid, 0);
    check({tag, "_o0_data"},  o0_data,  0);
    check({tag, "_o1_data"},  o1_data,  0);
    check({tag, "_cnt0"},     {16'h0, cnt0}, 0);
    check({tag, "_cnt1"},     {16'h0, cnt1}, 0);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    logic [31:0] word;
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    cnt_exp0 = '0;
    cnt_exp1 = '0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h0;
    s        = 1'b0;
    o0_ready = 1'b0;
    o1_ready = 1'b0;

    // Held in reset with a word offered: nothing may be accepted.
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    check("post_reset_in_ready", in_ready, 1);
    mon_en = 1'b1;

    // First word to channel 0, visible one cycle later.
    step(1, 0, 32'hA5A5_0001, 0, 0, 0, 1);

    // Fill channel 1; third word blocked; switching s lands in channel 0.
    step(1, 1, 32'hB000_0001, 0, 0, 0, 1);
    step(1, 1, 32'hB000_0002, 0, 0, 0, 1);
    step(1, 1, 32'hB000_0003, 0, 0, 0, 0);
    step(1, 0, 32'hC000_0001, 0, 0, 0, 1);

    // Channel 0 full and popping: no bypass, then the word is accepted.
    step(1, 0, 32'hC000_0002, 1, 0, 0, 0);
    step(1, 0, 32'hC000_0002, 0, 0, 0, 1);
    step(0, 0, 32'h0,         1, 0, 0, 0);
    step(0, 0, 32'h0,         1, 0, 0, 1);

    // Channel 1 down to one word, then push and pop on the same edge.
    step(0, 1, 32'h0,         0, 1, 0, 0);
    step(1, 1, 32'hD000_0001, 0, 1, 0, 1);
    step(0, 1, 32'h0,         0, 0, 0, 1);

    // Both channels busy, then a one-cycle flush with pops requested.
    step(1, 0, 32'hE000_0001, 0, 0, 0, 1);
    step(1, 0, 32'hE000_0002, 1, 1, 1, 0);
    step(0, 0, 32'h0,         0, 0, 0, 1);
    check("flush_o0_valid", o0_valid, 0);
    check("flush_o1_valid", o1_valid, 0);
    check("flush_cnt0", {16'h0, cnt0}, 32'd4);
    check("flush_cnt1", {16'h0, cnt1}, 32'd3);

    // Stream into channel 0 with the consumer always ready until the
    // transfer counter reaches its maximum, then wrap it.
    word = 32'h1000_0000;
    while (cnt_exp0 != 16'hFFFF) begin
      step(1, 0, word, 1, 0, 0, 1);
      word = word + 32'd1;
    end
    check("cnt0_max", {16'h0, cnt0}, 32'h0000_FFFF);
    step(1, 0, word, 1, 0, 0, 1);
    check("cnt0_wrap", {16'h0, cnt0}, 32'h0);
    step(0, 0, 32'h0, 1, 0, 0, 1);

    // Leave a word in channel 1, then pulse reset between clock edges.
    step(1, 1, 32'hF000_0001, 0, 0, 0, 1);
    in_valid = 1'b0;
    s        = 1'b0;
    o0_ready = 1'b0;
    o1_ready = 1'b0;
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_all_zero("mid_reset");
    q0.delete();
    q1.delete();
    cnt_exp0 = '0;
    cnt_exp1 = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rerelease_in_ready", in_ready, 1);
    mon_en = 1'b1;
    step(1, 0, 32'h5A5A_0002, 0, 0, 0, 1);
    step(0, 0, 32'h0,         0, 0, 0, 1);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
